// File: rtl/pc_next_unit_pkg.sv
// Shared core definitions: branch funct3 codes, PC-unit FSM states and
// default reset/trap vectors.
package pc_next_unit_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// Control/operand bus between decode/ALU and the PC unit.
interface pc_next_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            branch;
  logic [2:0]      br_type;
  logic            jal;
  logic            jalr;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] imm_ext;
  logic            ext_redir;
  logic [XLEN-1:0] ext_pc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            taken;
  logic            trap;
  logic [XLEN-1:0] epc;
  logic            pending;

  modport master (
    output stall, branch, br_type, jal, jalr, op_a, op_b, imm_ext,
           ext_redir, ext_pc,
    input  pc, pc_plus4, taken, trap, epc, pending
  );

  modport slave (
    input  stall, branch, br_type, jal, jalr, op_a, op_b, imm_ext,
           ext_redir, ext_pc,
    output pc, pc_plus4, taken, trap, epc, pending
  );
endinterface

// File: rtl/pc_next_unit_branch_cmp.sv
// Combinational RV32 branch condition evaluator; unused funct3 codes
// (010/011) resolve to not-taken.
module branch_cmp
  import pc_next_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      br_type,
  output logic            cond
);

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BEQ:  cond = (op_a == op_b);
      BR_BNE:  cond = (op_a != op_b);
      BR_BLT:  cond = ($signed(op_a) <  $signed(op_b));
      BR_BGE:  cond = ($signed(op_a) >= $signed(op_b));
      BR_BLTU: cond = (op_a <  op_b);
      BR_BGEU: cond = (op_a >= op_b);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Architectural PC register with branch/jump resolution, misaligned-target
// trap and a stall-tolerant external redirect buffer.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [XLEN-1:0] TRAP_VEC  = DEF_TRAP_VEC,
  parameter int              IALIGN    = 4
) (
  input  logic           clk,
  input  logic           reset,
  pc_next_unit_if.slave  bus
);

  localparam int AB = $clog2(IALIGN);

  pc_state_e       state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] redir_tgt;
  logic            trap_q;

  logic            cond;
  logic            taken;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] ext_al;
  logic            misalign;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .op_a    (bus.op_a),
    .op_b    (bus.op_b),
    .br_type (bus.br_type),
    .cond    (cond)
  );

  assign pc_plus4 = pc_q + XLEN'(4);
  assign br_tgt   = pc_q + bus.imm_ext;
  assign jalr_sum = bus.op_a + bus.imm_ext;
  assign taken    = bus.jal | bus.jalr | (bus.branch & cond);

  // JAL and branch share pc+imm; only JALR differs, so it alone needs priority.
  assign target   = bus.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_tgt;
  assign misalign = taken && (target[AB-1:0] != '0);
  assign ext_al   = {bus.ext_pc[XLEN-1:AB], {AB{1'b0}}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      redir_tgt <= '0;
      trap_q    <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.stall) begin
            if (bus.ext_redir) begin
              state     <= ST_PEND;
              redir_tgt <= ext_al;
            end
          end else if (bus.ext_redir) begin
            pc_q <= ext_al;
          end else if (misalign) begin
            pc_q   <= TRAP_VEC;
            epc_q  <= pc_q;
            trap_q <= 1'b1;
          end else if (taken) begin
            pc_q <= target;
          end else begin
            pc_q <= pc_plus4;
          end
        end
        ST_PEND: begin
          // The buffered redirect owns the first unstalled cycle.
          if (bus.stall) begin
            if (bus.ext_redir) redir_tgt <= ext_al;
          end else begin
            pc_q  <= redir_tgt;
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.taken    = taken;
  assign bus.trap     = trap_q;
  assign bus.epc      = epc_q;
  assign bus.pending  = (state == ST_PEND);

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit; a second instance with IALIGN=2 covers
// the halfword-aligned JALR case.
module tb_pc_next_unit;
  import pc_next_unit_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        trap;
    logic        pending;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_next_unit_if #(.XLEN(32)) bus4 ();
  pc_next_unit_if #(.XLEN(32)) bus2 ();

  pc_next_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .IALIGN(4)) dut (
    .clk(clk), .reset(reset), .bus(bus4));

  pc_next_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .IALIGN(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [2:0] bt,
                       input logic j, input logic jr, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm,
                       input logic er, input logic [31:0] epc_in);
    bus4.stall = st; bus4.branch = br; bus4.br_type = bt; bus4.jal = j;
    bus4.jalr = jr; bus4.op_a = a; bus4.op_b = b; bus4.imm_ext = imm;
    bus4.ext_redir = er; bus4.ext_pc = epc_in;
    bus2.stall = st; bus2.branch = br; bus2.br_type = bt; bus2.jal = j;
    bus2.jalr = jr; bus2.op_a = a; bus2.op_b = b; bus2.imm_ext = imm;
    bus2.ext_redir = er; bus2.ext_pc = epc_in;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Expected state is queued at drive time and compared after the edge.
  task automatic tick(input string tag, input logic [31:0] pc_e, input logic [31:0] epc_e,
                      input logic trap_e, input logic pend_e);
    exp_t e, g;
    e.pc = pc_e; e.epc = epc_e; e.trap = trap_e; e.pending = pend_e;
    sb.push_back(e);
    #1;
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({tag, ".pc"},      bus4.pc,              g.pc);
    check({tag, ".epc"},     bus4.epc,             g.epc);
    check({tag, ".trap"},    {31'b0, bus4.trap},    {31'b0, g.trap});
    check({tag, ".pending"}, {31'b0, bus4.pending}, {31'b0, g.pending});
  endtask

  task automatic cmb(input string tag, input logic taken_e, input logic [31:0] p4_e);
    #1;
    check({tag, ".taken"},    {31'b0, bus4.taken}, {31'b0, taken_e});
    check({tag, ".pc_plus4"}, bus4.pc_plus4,       p4_e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst.pc", bus4.pc, 32'h0);
    check("rst.epc", bus4.epc, 32'h0);
    check("rst.trap", {31'b0, bus4.trap}, 32'h0);
    check("rst.pending", {31'b0, bus4.pending}, 32'h0);
    cmb("rst", 1'b0, 32'h4);
    reset = 1'b1;

    // Sequential fetch
    idle(); cmb("seq0", 1'b0, 32'h4);
    tick("seq0", 32'h4, 32'h0, 1'b0, 1'b0);
    idle(); tick("seq1", 32'h8, 32'h0, 1'b0, 1'b0);

    // BLTU -1 vs 1 at pc=8: unsigned, not taken
    drive(1'b0, 1'b1, BR_BLTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'd16, 1'b0, 32'h0);
    cmb("bltu", 1'b0, 32'hC);
    tick("bltu", 32'hC, 32'h0, 1'b0, 1'b0);

    // Redirect back to 8, then BLT -1 < 1 taken to 24
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h8);
    tick("redir8", 32'h8, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, BR_BLT, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'd16, 1'b0, 32'h0);
    cmb("blt", 1'b1, 32'hC);
    tick("blt", 32'h18, 32'h0, 1'b0, 1'b0);

    // Condition sweep while stalled: pc holds at 24
    drive(1'b1, 1'b1, BR_BEQ, 1'b0, 1'b0, 32'h5, 32'h5, 32'd16, 1'b0, 32'h0);
    cmb("beq", 1'b1, 32'h1C); tick("stall_beq", 32'h18, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, BR_BNE, 1'b0, 1'b0, 32'h5, 32'h5, 32'd16, 1'b0, 32'h0);
    cmb("bne", 1'b0, 32'h1C); tick("stall_bne", 32'h18, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, BR_BGE, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'd16, 1'b0, 32'h0);
    cmb("bge", 1'b0, 32'h1C);
    drive(1'b1, 1'b1, BR_BGE, 1'b0, 1'b0, 32'h1, 32'h1, 32'd16, 1'b0, 32'h0);
    cmb("bge_eq", 1'b1, 32'h1C);
    drive(1'b1, 1'b1, BR_BGEU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'd16, 1'b0, 32'h0);
    cmb("bgeu", 1'b1, 32'h1C);
    drive(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 32'h7, 32'h7, 32'd16, 1'b0, 32'h0);
    cmb("f3_010", 1'b0, 32'h1C); tick("stall_010", 32'h18, 32'h0, 1'b0, 1'b0);

    // JAL backwards by 8
    drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0, 32'h0);
    cmb("jal", 1'b1, 32'h1C);
    tick("jal", 32'h10, 32'h0, 1'b0, 1'b0);

    // JALR 0x101+2 -> 0x102: traps at IALIGN=4, legal at IALIGN=2
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h101, 32'h0, 32'h2, 1'b0, 32'h0);
    cmb("jalr", 1'b1, 32'h14);
    tick("jalr_trap", 32'h100, 32'h10, 1'b1, 1'b0);
    check("jalr_ia2.pc", bus2.pc, 32'h102);
    check("jalr_ia2.trap", {31'b0, bus2.trap}, 32'h0);
    idle(); tick("post_trap", 32'h104, 32'h10, 1'b0, 1'b0);
    check("post_ia2.pc", bus2.pc, 32'h106);

    // Misaligned taken branch also traps
    drive(1'b0, 1'b1, BR_BEQ, 1'b0, 1'b0, 32'h3, 32'h3, 32'h2, 1'b0, 32'h0);
    tick("br_trap", 32'h100, 32'h104, 1'b1, 1'b0);
    idle(); tick("post_br_trap", 32'h104, 32'h104, 1'b0, 1'b0);

    // Stalled redirect, overwritten, applied over a taken BEQ
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h200);
    tick("buf200", 32'h104, 32'h104, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h300);
    tick("buf300", 32'h104, 32'h104, 1'b0, 1'b1);
    drive(1'b0, 1'b1, BR_BEQ, 1'b0, 1'b0, 32'h9, 32'h9, 32'h8, 1'b0, 32'h0);
    tick("apply", 32'h300, 32'h104, 1'b0, 1'b0);
    idle(); tick("post_apply", 32'h304, 32'h104, 1'b0, 1'b0);

    // Unaligned ext_pc is forced to alignment, never traps
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h203);
    tick("ext_align", 32'h200, 32'h104, 1'b0, 1'b0);

    // Reset while pending and stalled
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h400);
    tick("buf400", 32'h200, 32'h104, 1'b0, 1'b1);
    reset = 1'b0;
    tick("rst_pend", 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(); tick("after_rst", 32'h4, 32'h0, 1'b0, 1'b0);

    // Wrap-around from the top of the address space
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick("to_top", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    idle(); cmb("wrap", 1'b0, 32'h0);
    tick("wrap", 32'h0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
